// File: rtl/conv_window_mac_if.sv
// Window/weight/result bundle between the line buffer, conv_window_mac and the writeback stage.
interface conv_window_mac_if #(
    parameter int unsigned KERNEL_SIZE      = 3,
    parameter int unsigned FIXED_POINT_SIZE = 16
);
    localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE;

    logic [KK*FIXED_POINT_SIZE-1:0] dataIn;
    logic                           dataValidIn;
    logic                           weightLoadStart;
    logic [FIXED_POINT_SIZE-1:0]    weightIn;
    logic                           weightValidIn;
    logic                           weightsReady;
    logic [FIXED_POINT_SIZE-1:0]    dataOut;
    logic                           dataValidOut;

    modport master (
        output dataIn, dataValidIn, weightLoadStart, weightIn, weightValidIn,
        input  weightsReady, dataOut, dataValidOut
    );

    modport slave (
        input  dataIn, dataValidIn, weightLoadStart, weightIn, weightValidIn,
        output weightsReady, dataOut, dataValidOut
    );
endinterface

// File: rtl/conv_window_mac.sv
// K x K window multiply-accumulate with programmable signed fixed-point weights.
// Three-stage pipeline: products, accumulate, round/saturate.
module conv_window_mac #(
    parameter int unsigned KERNEL_SIZE      = 3,
    parameter int unsigned FIXED_POINT_SIZE = 16,
    parameter int unsigned FRAC_BITS        = 8
) (
    input  logic              clk,
    input  logic              resetn,
    conv_window_mac_if.slave  bus
);
    localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned W  = FIXED_POINT_SIZE;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned AW = PW + $clog2(KK);
    localparam int unsigned IW = (KK > 1) ? $clog2(KK) : 1;

    localparam logic signed [AW-1:0] HALF    = AW'(1) << (FRAC_BITS - 1);
    localparam logic signed [AW-1:0] SAT_MAX = AW'((longint'(1) << (W - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            we_c;
    logic            accept_c;

    logic signed [W-1:0]  weight_q [KK];
    logic signed [PW-1:0] prod_q   [KK];
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] sum_c;
    logic signed [AW-1:0] rnd_c;
    logic signed [AW-1:0] shf_c;
    logic signed [W-1:0]  sat_c;

    logic          v1_q, v2_q, vout_q;
    logic [W-1:0]  out_q;

    // Weight-load FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Load start wins over a same-cycle weight; writes only land while not ready
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_c    = 1'b0;
        if (bus.weightLoadStart) begin
            state_d = ST_LOAD;
            idx_d   = '0;
        end else if (state_q == ST_LOAD && bus.weightValidIn) begin
            we_c = 1'b1;
            if (idx_q == IW'(KK - 1)) begin
                idx_d   = '0;
                state_d = ST_READY;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    assign accept_c = bus.dataValidIn && (state_q == ST_READY);

    always_ff @(posedge clk) begin
        if (we_c) begin
            weight_q[idx_q] <= bus.weightIn;
        end
    end

    // Stage 1 datapath: products latch the weights in use, so a later reload cannot disturb them
    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int unsigned e = 0; e < KK; e++) begin
                prod_q[e] <= PW'($signed(bus.dataIn[e*W +: W])) * PW'(weight_q[e]);
            end
        end
        acc_q <= sum_c;
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned e = 0; e < KK; e++) begin
            sum_c = sum_c + AW'(prod_q[e]);
        end
    end

    // Round half toward +inf, then clamp into the W-bit signed range
    always_comb begin
        rnd_c = acc_q + HALF;
        shf_c = rnd_c >>> FRAC_BITS;
        if (shf_c > SAT_MAX) begin
            sat_c = W'(SAT_MAX);
        end else if (shf_c < SAT_MIN) begin
            sat_c = W'(SAT_MIN);
        end else begin
            sat_c = W'(shf_c);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            vout_q <= 1'b0;
            out_q  <= '0;
        end else begin
            v1_q   <= accept_c;
            v2_q   <= v1_q;
            vout_q <= v2_q;
            out_q  <= v2_q ? sat_c : '0;
        end
    end

    assign bus.weightsReady = (state_q == ST_READY);
    assign bus.dataValidOut = vout_q;
    assign bus.dataOut      = out_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed plus randomized bench for conv_window_mac against an arithmetic reference model.
module tb_conv_window_mac;
    localparam int unsigned K  = 3;
    localparam int unsigned W  = 16;
    localparam int unsigned F  = 8;
    localparam int unsigned KK = K * K;
    localparam longint PMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint PMIN = -PMAX - 1;

    typedef struct {
        int due;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int   mw [KK];
    bit   m_ready = 1'b0;
    int   m_idx   = 0;
    exp_t q [$];
    int   obs_log [$];

    conv_window_mac_if #(.KERNEL_SIZE(K), .FIXED_POINT_SIZE(W)) bus ();

    conv_window_mac #(
        .KERNEL_SIZE(K),
        .FIXED_POINT_SIZE(W),
        .FRAC_BITS(F)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sum of products, +0.5 LSB, floor division by 2^F, clamp
    function automatic int ref_px(input int d[KK], input int w[KK]);
        longint s;
        longint r;
        longint den;
        den = longint'(1) << F;
        s = 0;
        for (int e = 0; e < KK; e++) s += longint'(d[e]) * longint'(w[e]);
        s += den / 2;
        if (s >= 0) r = s / den;
        else        r = -((-s + den - 1) / den);
        if (r > PMAX) r = PMAX;
        if (r < PMIN) r = PMIN;
        return int'(r);
    endfunction

    task automatic model_edge();
        int d[KK];
        if (!resetn) begin
            q.delete();
            m_ready = 1'b0;
            m_idx   = 0;
            return;
        end
        if (bus.dataValidIn && m_ready) begin
            for (int e = 0; e < KK; e++) d[e] = int'($signed(bus.dataIn[e*W +: W]));
            q.push_back('{due: cyc + 2, val: ref_px(d, mw)});
        end
        if (bus.weightLoadStart) begin
            m_ready = 1'b0;
            m_idx   = 0;
        end else if (!m_ready && bus.weightValidIn) begin
            mw[m_idx] = int'($signed(bus.weightIn));
            if (m_idx == KK - 1) begin
                m_idx   = 0;
                m_ready = 1'b1;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic tick();
        int ev;
        int ed;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        ev = 0;
        ed = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = 1;
            ed = q[0].val;
            void'(q.pop_front());
        end
        check("dataValidOut", 32'(bus.dataValidOut), ev);
        check("dataOut", 32'($signed(bus.dataOut)), ed);
        check("weightsReady", 32'(bus.weightsReady), 32'(m_ready));
        if (bus.dataValidOut === 1'b1) obs_log.push_back(int'($signed(bus.dataOut)));
    endtask

    function automatic int rnd_px();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic set_window(input int d[KK]);
        logic [KK*W-1:0] p;
        for (int e = 0; e < KK; e++) p[e*W +: W] = W'(d[e]);
        bus.dataIn      = p;
        bus.dataValidIn = 1'b1;
    endtask

    task automatic rand_window(input bit force_valid);
        int d[KK];
        for (int e = 0; e < KK; e++) d[e] = rnd_px();
        set_window(d);
        if (!force_valid) bus.dataValidIn = ($urandom_range(0, 3) != 0);
    endtask

    task automatic load(input int w[KK], input bit noisy);
        int e;
        bit v;
        bus.dataValidIn     = 1'b0;
        bus.weightLoadStart = 1'b1;
        bus.weightValidIn   = 1'b1;
        bus.weightIn        = W'(rnd_px());
        tick();
        bus.weightLoadStart = 1'b0;
        e = 0;
        while (e < KK) begin
            v = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.weightValidIn = v;
            bus.weightIn      = W'(w[e]);
            if (noisy) rand_window(1'b0);
            else       bus.dataValidIn = 1'b0;
            tick();
            if (v) e++;
        end
        // A stray weight once the set is complete must be ignored
        bus.dataValidIn   = 1'b0;
        bus.weightValidIn = 1'b1;
        bus.weightIn      = W'(rnd_px());
        tick();
        bus.weightValidIn = 1'b0;
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        check({tag, "_count"}, obs_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs_log.size(); i++) check(tag, obs_log[i], exp[i]);
    endtask

    initial begin
        int w[KK];
        int d[KK];
        int ex[$];
        int vals[5];

        resetn              = 1'b0;
        bus.dataIn          = '0;
        bus.dataValidIn     = 1'b0;
        bus.weightLoadStart = 1'b0;
        bus.weightIn        = '0;
        bus.weightValidIn   = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;

        // Window before any weights: dropped
        obs_log.delete();
        for (int e = 0; e < KK; e++) d[e] = 256;
        set_window(d);
        tick();
        bus.dataValidIn = 1'b0;

        for (int e = 0; e < KK; e++) w[e] = 256;
        load(w, 1'b0);
        set_window(d);
        tick();
        bus.dataValidIn = 1'b0;
        repeat (4) tick();
        ex = '{2304};
        check_log("ones", ex);

        // Identity kernel, back-to-back windows
        for (int e = 0; e < KK; e++) w[e] = 0;
        w[4] = 256;
        load(w, 1'b0);
        obs_log.delete();
        vals = '{100, -7, 0, 32767, -32768};
        for (int i = 0; i < 5; i++) begin
            for (int e = 0; e < KK; e++) d[e] = rnd_px();
            d[4] = vals[i];
            set_window(d);
            tick();
        end
        bus.dataValidIn = 1'b0;
        repeat (4) tick();
        ex = '{100, -7, 0, 32767, -32768};
        check_log("identity", ex);

        // Saturation at both rails
        for (int e = 0; e < KK; e++) w[e] = 32767;
        load(w, 1'b0);
        obs_log.delete();
        for (int e = 0; e < KK; e++) d[e] = 32767;
        set_window(d);
        tick();
        for (int e = 0; e < KK; e++) d[e] = -32768;
        set_window(d);
        tick();
        bus.dataValidIn = 1'b0;
        repeat (4) tick();
        ex = '{32767, -32768};
        check_log("saturate", ex);

        // Rounding with a 0.5 weight
        for (int e = 0; e < KK; e++) w[e] = 0;
        w[0] = 128;
        load(w, 1'b0);
        obs_log.delete();
        vals = '{3, -3, 1, 0, 0};
        for (int i = 0; i < 3; i++) begin
            for (int e = 0; e < KK; e++) d[e] = rnd_px();
            d[0] = vals[i];
            set_window(d);
            tick();
        end
        bus.dataValidIn = 1'b0;
        repeat (4) tick();
        ex = '{2, -1, 1};
        check_log("round", ex);

        // Reload with two windows in flight; windows during reload dropped
        obs_log.delete();
        vals = '{10, -10, 0, 0, 0};
        for (int i = 0; i < 2; i++) begin
            for (int e = 0; e < KK; e++) d[e] = rnd_px();
            d[0] = vals[i];
            set_window(d);
            tick();
        end
        for (int e = 0; e < KK; e++) w[e] = 0;
        w[4] = 256;
        load(w, 1'b1);
        for (int e = 0; e < KK; e++) d[e] = rnd_px();
        d[4] = 1234;
        set_window(d);
        tick();
        bus.dataValidIn = 1'b0;
        repeat (4) tick();
        ex = '{5, -5, 1234};
        check_log("reload", ex);

        // Reset with three windows in flight
        obs_log.delete();
        rand_window(1'b1);
        tick();
        rand_window(1'b1);
        tick();
        rand_window(1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        bus.dataValidIn = 1'b0;
        repeat (5) tick();
        rand_window(1'b1);
        tick();
        bus.dataValidIn = 1'b0;
        repeat (4) tick();
        ex.delete();
        check_log("reset_flush", ex);
        check("ready_after_reset", 32'(bus.weightsReady), 0);

        // Randomized weights and window streams
        for (int r = 0; r < 4; r++) begin
            for (int e = 0; e < KK; e++) w[e] = rnd_px();
            if (r == 0) for (int e = 0; e < KK; e++) w[e] = int'($urandom_range(0, 512)) - 256;
            load(w, 1'b1);
            repeat (40) begin
                rand_window(1'b0);
                bus.weightValidIn = ($urandom_range(0, 7) == 0);
                bus.weightIn      = W'(rnd_px());
                tick();
            end
            bus.dataValidIn   = 1'b0;
            bus.weightValidIn = 1'b0;
            repeat (4) tick();
        end
        check("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
